// File: rtl/logic_array_pipe_pkg.sv
// logic_pkg: op encoding and the reference logic function shared by the logic array pipeline.
package logic_pkg;
    localparam int MAX_W = 128;
    typedef enum logic [2:0] {
        OP_NAND  = 3'b000,
        OP_AND   = 3'b001,
        OP_OR    = 3'b010,
        OP_NOR   = 3'b011,
        OP_XOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;
    // Operates at the widest supported width; callers zero-extend operands and truncate the result.
    function automatic logic [MAX_W-1:0] logic_op(input op_e op, input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
        case (op)
            OP_NAND: logic_op = ~(a & b);
            OP_AND:  logic_op = a & b;
            OP_OR:   logic_op = a | b;
            OP_NOR:  logic_op = ~(a | b);
            OP_XOR:  logic_op = a ^ b;
            OP_XNOR: logic_op = ~(a ^ b);
            OP_NOTA: logic_op = ~a;
            default: logic_op = a;
        endcase
    endfunction
endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: one valid/data register stage; loads when advanced, holds otherwise.
module logic_pipe_stage
    import logic_pkg::*;
#(
    parameter int DW = 66
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_adv,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);
    logic          r_valid;
    logic [DW-1:0] r_data;
    // Bubbles do not overwrite data, so the word stays put until real data replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/logic_array_pipe.sv
// logic_array_pipe: pipelined bitwise logic unit with zero/all-ones flags and valid/ready on both sides.
module logic_array_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones
);
    localparam int DW = WIDTH + 2;
    logic [WIDTH-1:0] w_y;
    logic             w_zero;
    logic             w_ones;
    logic [LATENCY:0]   w_adv;
    logic [LATENCY-1:0] w_v;
    logic [LATENCY-1:0] w_vin;
    logic [DW-1:0]      w_d   [LATENCY];
    logic [DW-1:0]      w_din [LATENCY];
    assign w_y    = WIDTH'(logic_op(op_e'(in_op), MAX_W'(in_a), MAX_W'(in_b)));
    assign w_zero = ~|w_y;
    assign w_ones = &w_y;
    // A stage may load when it is empty or when its content leaves this cycle.
    always_comb begin
        w_adv[LATENCY] = out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) w_adv[k] = !w_v[k] || w_adv[k+1];
    end
    assign in_ready = rst || w_adv[0];
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_vin[i] = in_valid;
            assign w_din[i] = {w_y, w_zero, w_ones};
        end else begin : g_tail
            assign w_vin[i] = w_v[i-1];
            assign w_din[i] = w_d[i-1];
        end
        logic_pipe_stage #(.DW(DW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_adv   (w_adv[i]),
            .i_valid (w_vin[i]),
            .i_data  (w_din[i]),
            .o_valid (w_v[i]),
            .o_data  (w_d[i])
        );
    end
    assign out_valid                    = w_v[LATENCY-1];
    assign {out_y, out_zero, out_ones} = w_d[LATENCY-1];
endmodule

// File: doc/logic_array_pipe.md
# logic_array_pipe

Parametrised, pipelined bitwise logic unit for the double-precision datapath. Applies one of eight two-operand logic operations (NAND, AND, OR, NOR, XOR, XNOR, NOT-A, PASS-A) across a WIDTH-bit word. It also flags all-zero and all-ones results, which the exponent/mantissa special-case logic uses to detect zero, infinity and NaN. It sits between operand unpacking and the Vedic partial-product stages, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 64, operand/result width in bits (1..128)
- LATENCY, 2, register stages from accept to result (1..4)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand word present
- in_ready  out  1  block accepts operands this cycle
- in_op  in  3  operation select (see Operation)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored for NOT-A, PASS-A)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_y  out  WIDTH  result word
- out_zero  out  1  out_y == 0
- out_ones  out  1  out_y == all ones

## Operation
- Op encoding (shared package):
  - 000 NAND: ~(a&b)
  - 001 AND
  - 010 OR
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT-A
  - 111 PASS-A
- All codes are defined. There is no illegal-op path.
- Transfer happens on a rising edge when valid && ready on the respective side.
- Pipeline:
  - LATENCY stages, each holding {valid, y, zero, ones}.
  - Stage 0 computes the logic op on the accepted operands.
  - Zero/ones reduction is computed in stage 0 and carried alongside y. No late recompute.
  - Later stages are pure registers.
- Stage advance rule:
  - Stage k loads from stage k-1 when stage k is empty, or when stage k is being emptied this cycle.
  - Bubbles collapse. A stall holds only the stages that are full.
- in_ready = !stage0.valid || stage0 advancing. It is combinational from out_ready through the advance chain; no combinational path from in_valid.
- out_valid/out_y/out_zero/out_ones come directly from the last stage's registers.
- While out_valid && !out_ready:
  - out_y, out_zero, out_ones hold stable.
  - No result is lost or duplicated.
- Results leave in acceptance order.

## Timing
- Reset (synchronous, rst high at a rising edge):
  - All stage valid bits clear; out_valid=0.
  - out_y=0, out_zero=0, out_ones=0.
  - in_ready=1 in the cycle after reset deasserts. in_ready reads 1 during reset as well; inputs are ignored while rst is high.
- Latency: operands accepted at edge N give out_valid=1 after edge N+LATENCY-1, i.e. visible in the cycle following that edge. LATENCY=1 gives a registered result one cycle after accept.
- Throughput: one result per cycle while out_ready=1.
- Full pipeline with out_ready=0: after LATENCY accepts, in_ready drops to 0.
- Full pipeline, stall released: a pop and a push in the same cycle are both legal. The pipeline stays full and in_ready=1 that cycle.
- Reset mid-operation: in-flight results are discarded, and no out_valid appears for them afterwards.
- in_valid with rst high: ignored.
- WIDTH=1: out_zero = ~out_y and out_ones = out_y.

## Structure
- Shared package logic_pkg holds:
  - the 3-bit op typedef and the eight op constants;
  - a function returning the op result for a given op and operands.
- Sub-module logic_pipe_stage: one register stage with valid, data and an advance input. It is instantiated LATENCY times via generate. Stage 0 is fed by the combinational op/reduction logic.
- Top-level logic_array_pipe holds the op logic, the reduction trees and the advance/ready chain.

## Test plan
- Reset, then drive in_a=64'hFFFF_0000_FFFF_0000, in_b=64'h0F0F_0F0F_0F0F_0F0F, op=000 with out_ready=1, LATENCY=2. Require out_y=64'hF0F0_FFFF_F0F0_FFFF, out_zero=0, out_ones=0, and out_valid exactly 2 cycles after accept.
- All 8 ops back-to-back with in_a=64'hAAAA_AAAA_AAAA_AAAA, in_b=64'h5555_5555_5555_5555. Require one result per cycle in order:
  - NAND → all ones, out_ones=1;
  - AND → 0, out_zero=1;
  - OR → all ones;
  - NOR → 0;
  - XOR → all ones;
  - XNOR → 0;
  - NOT-A → 64'h5555…;
  - PASS-A → 64'hAAAA….
- Hold out_ready=0 for 6 cycles while offering 4 distinct words. Require:
  - exactly LATENCY words accepted, then in_ready=0;
  - out_y stable during the stall;
  - on release, all 4 words emerge in order with no duplicates.
- Random in_valid/out_ready (50% each), 2000 transactions, LATENCY ∈ {1,2,4}, WIDTH ∈ {1,11,64}. The scoreboard matches every result against the package function, including zero/ones flags.
- Assert rst for one cycle with the pipeline full. Require out_valid=0 and out_y=0 the next cycle, no stale results later, and a new operand accepted immediately after reset producing the correct result.
